// File: rtl/display_scan_mux.sv
// display_scan_mux: multiplexed 7-segment driver with a glyph buffer that only updates at frame boundaries.
// Define SCAN_BLINK_EN to blank the segments on alternate BLINK_FRAMES-frame periods while piscar is high.
module display_scan_mux #(
  parameter int N_DIGITS     = 4,
  parameter int CLK_DIV      = 1000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [4*N_DIGITS-1:0] caracteres,
  input  logic                  carregar,
  input  logic                  piscar,
  output logic                  pendente,
  output logic [6:0]            segmentos,
  output logic [N_DIGITS-1:0]   anodos
);
  localparam int PW = $clog2(CLK_DIV);
  localparam int IW = N_DIGITS > 2 ? $clog2(N_DIGITS) : 1;
  localparam logic [6:0] ROM [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                      7'h7F, 7'h6F, 7'h79, 7'h6D, 7'h73, 7'h39, 7'h40, 7'h00};
  logic [PW-1:0]              r_presc;
  logic [IW-1:0]              r_idx;
  logic [N_DIGITS-1:0][3:0]   r_shadow, r_stage;
  logic                       w_tick, w_frame, w_blank;
  logic [6:0]                 w_glyph;
  assign w_tick  = r_presc == PW'(CLK_DIV - 1);
  assign w_frame = w_tick && r_idx == IW'(N_DIGITS - 1);
  assign w_glyph = ROM[r_shadow[r_idx]];
`ifdef SCAN_BLINK_EN
  localparam int FW = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;
  logic [FW-1:0] r_fc;
  logic          r_phase;
  assign w_blank = piscar & r_phase;
  always_ff @(posedge clock) begin
    if (reset) begin
      r_fc    <= '0;
      r_phase <= 1'b0;
    end else if (w_frame) begin
      r_fc    <= r_fc == FW'(BLINK_FRAMES - 1) ? '0 : r_fc + 1'b1;
      r_phase <= r_phase ^ (r_fc == FW'(BLINK_FRAMES - 1));
    end
  end
`else
  logic w_unused;
  assign w_unused = piscar & (BLINK_FRAMES > 0);
  assign w_blank  = 1'b0;
`endif
  always_ff @(posedge clock) begin
    if (reset) begin
      r_presc   <= '0;
      r_idx     <= '0;
      r_shadow  <= {N_DIGITS{4'hF}};
      r_stage   <= {N_DIGITS{4'hF}};
      pendente  <= 1'b0;
      segmentos <= 7'h7F;
      anodos    <= '1;
    end else begin
      r_presc <= w_tick ? '0 : r_presc + 1'b1;
      if (w_tick) r_idx <= w_frame ? '0 : r_idx + 1'b1;
      if (carregar) r_stage <= caracteres;
      // a load landing on the boundary itself supersedes the staged data, so skip this copy
      if (w_frame && pendente && !carregar) r_shadow <= r_stage;
      pendente  <= carregar | (pendente & ~w_frame);
      anodos    <= ~(N_DIGITS'(1) << r_idx);
      segmentos <= w_blank ? 7'h7F : ~w_glyph;
    end
  end
endmodule

// File: tb/tb_display_scan_mux.sv
// tb_display_scan_mux: directed checks of scan order, frame-aligned loads, reset and optional blinking.
module tb_display_scan_mux;
  logic        clock = 1'b0;
  logic        reset, carregar, piscar, pendente;
  logic [15:0] caracteres;
  logic [6:0]  segmentos;
  logic [3:0]  anodos;
  int          ncmp = 0, nerr = 0, cyc = 0;
  logic [3:0]  an_tbl [4] = '{4'hE, 4'hD, 4'hB, 4'h7};

  display_scan_mux #(.N_DIGITS(4), .CLK_DIV(4), .BLINK_FRAMES(2)) dut (
    .clock(clock), .reset(reset), .caracteres(caracteres), .carregar(carregar),
    .piscar(piscar), .pendente(pendente), .segmentos(segmentos), .anodos(anodos)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic go(input int k);
    while (cyc < k) step();
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s @cyc %0d: observed %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  task automatic load(input logic [15:0] v);
    caracteres = v;
    carregar = 1'b1;
    step();
    carregar = 1'b0;
  endtask

  initial begin
    reset = 1'b1; carregar = 1'b0; piscar = 1'b0; caracteres = '0;
    repeat (3) step();
    chk("rst_seg", {1'b0, segmentos}, 8'h7F);
    chk("rst_an", {4'h0, anodos}, 8'h0F);
    chk("rst_pend", {7'h0, pendente}, 8'h00);
    reset = 1'b0;
    cyc = 0;
    for (int k = 1; k <= 16; k++) begin
      step();
      chk("scan_an", {4'h0, anodos}, {4'h0, an_tbl[(k-1)/4]});
      chk("scan_seg", {1'b0, segmentos}, 8'h7F);
    end
    chk("scan_pend", {7'h0, pendente}, 8'h00);
    // single load mid-frame
    go(20);
    load(16'hFCBA);
    chk("ld_pend", {7'h0, pendente}, 8'h01);
    go(31); chk("ld_pend_hold", {7'h0, pendente}, 8'h01);
    go(32); chk("ld_pend_clr", {7'h0, pendente}, 8'h00);
    chk("ld_old_seg", {1'b0, segmentos}, 8'h7F);
    go(33); chk("ld_d0_an", {4'h0, anodos}, 8'h0E); chk("ld_d0_seg", {1'b0, segmentos}, 8'h06);
    go(37); chk("ld_d1_an", {4'h0, anodos}, 8'h0D); chk("ld_d1_seg", {1'b0, segmentos}, 8'h12);
    go(41); chk("ld_d2_an", {4'h0, anodos}, 8'h0B); chk("ld_d2_seg", {1'b0, segmentos}, 8'h0C);
    go(45); chk("ld_d3_an", {4'h0, anodos}, 8'h07); chk("ld_d3_seg", {1'b0, segmentos}, 8'h7F);
    // two loads in one frame: last wins, the first is never shown
    go(50);
    load(16'h1111);
    go(52);
    load(16'h8888);
    chk("dbl_pend", {7'h0, pendente}, 8'h01);
    while (cyc < 80) begin
      step();
      ncmp++;
      assert (segmentos !== 7'h79) else begin
        nerr++;
        $error("FAIL dbl_never1 @cyc %0d: observed %h expected not 79", cyc, segmentos);
      end
      if (cyc == 64) chk("dbl_pend_clr", {7'h0, pendente}, 8'h00);
      if (cyc == 65 || cyc == 69 || cyc == 73 || cyc == 77) chk("dbl_seg8", {1'b0, segmentos}, 8'h00);
    end
    // load coincident with the boundary tick at edge 96
    go(95);
    load(16'h0000);
    chk("bnd_pend", {7'h0, pendente}, 8'h01);
    go(97);  chk("bnd_keep_d0", {1'b0, segmentos}, 8'h00); chk("bnd_an0", {4'h0, anodos}, 8'h0E);
    go(109); chk("bnd_keep_d3", {1'b0, segmentos}, 8'h00); chk("bnd_an3", {4'h0, anodos}, 8'h07);
    go(111); chk("bnd_pend_hold", {7'h0, pendente}, 8'h01);
    go(113); chk("bnd_new_seg", {1'b0, segmentos}, 8'h40); chk("bnd_pend_clr", {7'h0, pendente}, 8'h00);
    // reset mid-frame with a load pending
    go(118);
    load(16'h2222);
    chk("mr_pend", {7'h0, pendente}, 8'h01);
    reset = 1'b1;
    step();
    chk("mr_seg", {1'b0, segmentos}, 8'h7F);
    chk("mr_an", {4'h0, anodos}, 8'h0F);
    chk("mr_pend_clr", {7'h0, pendente}, 8'h00);
    reset = 1'b0;
    cyc = 0;
    step();
    chk("mr_rel_an", {4'h0, anodos}, 8'h0E);
    chk("mr_rel_seg", {1'b0, segmentos}, 8'h7F);
    while (cyc < 40) begin
      step();
      chk("mr_no_stage", {1'b0, segmentos}, 8'h7F);
    end
`ifdef SCAN_BLINK_EN
    // phase is 1 for frames ending at edges 48,64 and 112,128; 0 for 80,96 and 144,160
    piscar = 1'b1;
    go(41);
    load(16'h8888);
    go(50);  chk("blk_off1", {1'b0, segmentos}, 8'h7F); chk("blk_an1", {4'h0, anodos}, 8'h0E);
    go(65);  chk("blk_on1", {1'b0, segmentos}, 8'h00);
    go(96);  chk("blk_on2", {1'b0, segmentos}, 8'h00);
    go(97);  chk("blk_off2", {1'b0, segmentos}, 8'h7F); chk("blk_an2", {4'h0, anodos}, 8'h0E);
    go(128); chk("blk_off3", {1'b0, segmentos}, 8'h7F); chk("blk_an3", {4'h0, anodos}, 8'h07);
    go(129); chk("blk_on3", {1'b0, segmentos}, 8'h00);
    piscar = 1'b0;
    go(140); chk("blk_ignored", {1'b0, segmentos}, 8'h00);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
